ref_clk_sel_readback: RTL and testbench
=======================================

# ref_clk_sel_readback

Status path for the reference-clock divider select: the return direction of the select decode. It samples the 5-bit transmission-gate enable vector fed back from the analog divider mux, which is asynchronous to `clk`. The vector is synchronized, deglitched, checked for one-hot, and re-encoded to the 3-bit select code so that slow control can confirm which divider (32/64/128/256/512) is actually engaged.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a new value is accepted; legal range 2..15.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `tgate_status` in 5: asynchronous enable readback. Bit 0 = /512, bit 1 = /256, bit 2 = /128, bit 3 = /64, bit 4 = /32.
- `err_clear` in 1: synchronous single-cycle request to clear `err_sticky`.
- `sel_code` out 3: encoded select. Bit n alone encodes to n (0..4).
- `sel_valid` out 1: accepted value is exactly one-hot.
- `sel_change` out 1: one-cycle pulse when the accepted value changes while locked.
- `onehot_err` out 1: accepted value is zero or multi-hot.
- `err_sticky` out 1: latched `onehot_err`.
- `filt_busy` out 1: high in SETTLING.

## Operation
- Synchronizer: 2 flops, reset 5'b0; its output is `s`.
- Filter registers:
  - `cand` (5b, reset 0) and `cnt` (4b, reset 0).
  - Each edge: if `s != cand`, then `cand <= s`, `cnt <= 1`; else `cnt` increments, saturating at `STABLE_CYCLES`.
  - Qualified when `s == cand && cnt == STABLE_CYCLES-1`.
- Accepted register `acc` is 5b with reset 5'b00010 (/256).
- Encoding of `acc`, all outputs registered:
  - One-hot: `sel_code` = bit index, `sel_valid` = 1, `onehot_err` = 0.
  - Zero or multi-hot: `sel_code` holds its last valid value, `sel_valid` = 0, `onehot_err` = 1.
- FSM states: INIT, LOCKED, SETTLING. Reset state is INIT.
  - INIT: on qualified, `acc <= cand`, go to LOCKED. No `sel_change` pulse. `sel_valid` and `onehot_err` are determined by the accepted value.
  - LOCKED: if `s != acc`, go to SETTLING (filter restarts as above).
  - SETTLING, `s == acc`: glitch return. Go to LOCKED next edge, `acc` unchanged, no pulse, `cnt <= STABLE_CYCLES`.
  - SETTLING, qualified with `cand != acc`: `acc <= cand`, pulse `sel_change` for 1 cycle, go to LOCKED.
- `err_sticky`:
  - Sets on the edge that `onehot_err` rises, and stays set while `onehot_err` = 1.
  - `err_clear` clears it on the next edge only if `onehot_err` = 0. Set wins over clear.
- Reset values: `sel_code` = 3'd1, `sel_valid` = 0, `sel_change` = 0, `onehot_err` = 0, `err_sticky` = 0, `filt_busy` = 0.
- `rst_n` low mid-operation: all state returns to reset values immediately and asynchronously. Deassertion restarts from INIT.

## Timing
- Let `tgate_status` be stable from capture edge k (first synchronizer flop) onward.
  - `s` changes after edge k+1.
  - `cand` updates on edge k+2.
  - `acc` and all outputs update on edge k+STABLE_CYCLES+1. With the default, that is 5 edges after capture.
- `sel_change` is high exactly one cycle, coincident with the first cycle of the new `sel_code`.
- Any input pattern held for fewer than `STABLE_CYCLES` synchronized samples is never accepted.
- A new change during SETTLING restarts `cnt` with no partial acceptance.
- `filt_busy` is registered and asserts on the edge after `s` departs from `acc`.
- Simultaneous qualified-invalid acceptance and `err_clear`: `err_sticky` remains 1.

## Test plan
- Reset, then hold `tgate_status` = 5'b00010:
  - During reset: `sel_code` = 1, `sel_valid` = 0.
  - 5 edges after capture: `sel_valid` = 1, `sel_code` = 1, no `sel_change` pulse.
- Locked at 5'b00010, step to 5'b10000:
  - `filt_busy` rises.
  - At edge k+5: `sel_code` = 4 and a single `sel_change` pulse.
- Locked at 5'b00001, glitch to 5'b00100 for 2 cycles, then return:
  - `sel_code` stays 0.
  - `sel_change` never pulses.
  - `filt_busy` returns to 0.
- Locked at code 3, drive 5'b01100 steadily:
  - `sel_valid` = 0, `onehot_err` = 1, `err_sticky` = 1, `sel_code` holds 3.
  - `err_clear` is ignored while the fault is present.
  - After 5'b00001 is restored and accepted, `err_clear` drops `err_sticky` next edge.
- Mid-SETTLING (5'b00010 → 5'b01000), assert `rst_n` = 0 asynchronously:
  - Outputs go to reset values immediately.
  - After release with 5'b01000 held, INIT accepts `sel_code` = 3 with no `sel_change` pulse.
- Step through all five one-hot inputs with `STABLE_CYCLES` = 2:
  - Codes 0..4 appear, each 3 edges after capture.
  - Each step produces one `sel_change` pulse.

Source files
------------

// File: rtl/ref_clk_sel_readback.sv
// Reference-clock divider select readback: sync, deglitch,
// one-hot check and re-encode of the analog tgate enables.
module ref_clk_sel_readback #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] tgate_status,
  input  logic       err_clear,
  output logic [2:0] sel_code,
  output logic       sel_valid,
  output logic       sel_change,
  output logic       onehot_err,
  output logic       err_sticky,
  output logic       filt_busy
);

  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);
  localparam logic [3:0] LAST = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    INIT,
    LOCKED,
    SETTLING
  } state_t;

  state_t     state, state_n;
  logic [4:0] sync1, s;
  logic [4:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] acc, acc_n;
  logic       load, chg_n, qual;
  logic       oh, err_n;
  logic [2:0] idx;

  assign qual = (s == cand) && (cnt == LAST);

  always_comb begin
    cand_n  = cand;
    cnt_n   = cnt;
    state_n = state;
    acc_n   = acc;
    load    = 1'b0;
    chg_n   = 1'b0;
    if (s != cand) begin
      cand_n = s;
      cnt_n  = 4'd1;
    end else if (cnt != STAB) begin
      cnt_n = cnt + 4'd1;
    end
    case (state)
      INIT: begin
        if (qual) begin
          acc_n   = cand;
          load    = 1'b1;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (s != acc) state_n = SETTLING;
      end
      SETTLING: begin
        // glitch came back to the locked value: resume as fully settled
        if (s == acc) begin
          state_n = LOCKED;
          cand_n  = s;
          cnt_n   = STAB;
        end else if (qual && cand != acc) begin
          acc_n   = cand;
          load    = 1'b1;
          chg_n   = 1'b1;
          state_n = LOCKED;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_comb begin
    oh  = (acc_n != 5'd0) && ((acc_n & (acc_n - 5'd1)) == 5'd0);
    idx = sel_code;
    if (oh) begin
      unique case (1'b1)
        acc_n[0]: idx = 3'd0;
        acc_n[1]: idx = 3'd1;
        acc_n[2]: idx = 3'd2;
        acc_n[3]: idx = 3'd3;
        acc_n[4]: idx = 3'd4;
        default:  idx = sel_code;
      endcase
    end
    err_n = load ? !oh : onehot_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 5'b0;
      s          <= 5'b0;
      cand       <= 5'b0;
      cnt        <= 4'd0;
      acc        <= 5'b00010;
      state      <= INIT;
      sel_code   <= 3'd1;
      sel_valid  <= 1'b0;
      sel_change <= 1'b0;
      onehot_err <= 1'b0;
      err_sticky <= 1'b0;
      filt_busy  <= 1'b0;
    end else begin
      sync1      <= tgate_status;
      s          <= sync1;
      cand       <= cand_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      state      <= state_n;
      sel_change <= chg_n;
      filt_busy  <= (state_n == SETTLING);
      if (load) begin
        sel_code   <= idx;
        sel_valid  <= oh;
        onehot_err <= !oh;
      end
      if (err_n) err_sticky <= 1'b1;
      else if (err_clear && !onehot_err) err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ref_clk_sel_readback.sv
// Directed bench for ref_clk_sel_readback:
// default filter depth plus a STABLE_CYCLES=2 instance.
module tb_ref_clk_sel_readback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] tgate, tgate2;
  logic       err_clear, err_clear2;
  logic [2:0] code, code2;
  logic       valid, chg, err, sticky, busy;
  logic       valid2, chg2, err2, sticky2, busy2;
  int         n_chk = 0;
  int         n_fail = 0;
  int         chg_cnt = 0;
  int         chg2_cnt = 0;
  int         base;

  always #5 clk = ~clk;

  ref_clk_sel_readback dut (
    .clk(clk), .rst_n(rst_n), .tgate_status(tgate),
    .err_clear(err_clear), .sel_code(code), .sel_valid(valid),
    .sel_change(chg), .onehot_err(err), .err_sticky(sticky),
    .filt_busy(busy)
  );

  ref_clk_sel_readback #(.STABLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tgate_status(tgate2),
    .err_clear(err_clear2), .sel_code(code2), .sel_valid(valid2),
    .sel_change(chg2), .onehot_err(err2), .err_sticky(sticky2),
    .filt_busy(busy2)
  );

  always @(negedge clk) begin
    if (chg) chg_cnt++;
    if (chg2) chg2_cnt++;
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    tgate      = 5'b00010;
    tgate2     = 5'b00010;
    err_clear  = 1'b0;
    err_clear2 = 1'b0;
    tick(1);
    chk("rst_code", code, 1);
    chk("rst_valid", valid, 0);
    chk("rst_chg", chg, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_busy", busy, 0);
    tick(1);
    rst_n = 1'b1;
    base = chg_cnt;
    tick(5);
    chk("init_pre_valid", valid, 0);
    tick(1);
    chk("init_valid", valid, 1);
    chk("init_code", code, 1);
    chk("init_chg", chg, 0);
    tick(2);
    chk("init_pulses", chg_cnt - base, 0);

    tgate = 5'b10000;
    base = chg_cnt;
    tick(2);
    chk("step_busy_pre", busy, 0);
    tick(1);
    chk("step_busy", busy, 1);
    tick(2);
    chk("step_code_pre", code, 1);
    tick(1);
    chk("step_code", code, 4);
    chk("step_chg", chg, 1);
    tick(1);
    chk("step_chg_end", chg, 0);
    chk("step_busy_end", busy, 0);
    chk("step_pulses", chg_cnt - base, 1);

    tgate = 5'b00001;
    tick(8);
    chk("g_lock_code", code, 0);
    base = chg_cnt;
    tgate = 5'b00100;
    tick(2);
    tgate = 5'b00001;
    tick(2);
    chk("g_busy", busy, 1);
    tick(8);
    chk("g_code", code, 0);
    chk("g_valid", valid, 1);
    chk("g_busy_end", busy, 0);
    chk("g_pulses", chg_cnt - base, 0);

    tgate = 5'b01000;
    tick(8);
    chk("e_lock_code", code, 3);
    tgate = 5'b01100;
    tick(8);
    chk("e_valid", valid, 0);
    chk("e_err", err, 1);
    chk("e_sticky", sticky, 1);
    chk("e_code", code, 3);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
    chk("e_clr_ignored", sticky, 1);
    tgate = 5'b00001;
    tick(8);
    chk("e_rec_valid", valid, 1);
    chk("e_rec_code", code, 0);
    chk("e_rec_err", err, 0);
    chk("e_rec_sticky", sticky, 1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    chk("e_clr", sticky, 0);

    tgate = 5'b00000;
    tick(5);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    chk("z_err", err, 1);
    chk("z_valid", valid, 0);
    chk("z_set_wins", sticky, 1);

    tgate = 5'b00010;
    tick(8);
    chk("r_lock_code", code, 1);
    tgate = 5'b01000;
    tick(3);
    chk("r_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_code", code, 1);
    chk("r_valid", valid, 0);
    chk("r_busy0", busy, 0);
    chk("r_chg", chg, 0);
    chk("r_err", err, 0);
    chk("r_sticky", sticky, 0);
    tick(2);
    rst_n = 1'b1;
    base = chg_cnt;
    tick(5);
    chk("r_pre_valid", valid, 0);
    chk("r_pre_code", code, 1);
    tick(1);
    chk("r_init_code", code, 3);
    chk("r_init_valid", valid, 1);
    chk("r_init_chg", chg, 0);
    tick(2);
    chk("r_pulses", chg_cnt - base, 0);

    chk("s2_lock_code", code2, 1);
    for (int i = 0; i < 5; i++) begin
      tgate2 = 5'd1 << i;
      base = chg2_cnt;
      tick(3);
      chk("s2_old_code", code2, (i == 0) ? 1 : i - 1);
      tick(1);
      chk("s2_code", code2, i);
      chk("s2_chg", chg2, 1);
      tick(2);
      chk("s2_pulses", chg2_cnt - base, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
